// File: rtl/trojan_pkg.sv
// Shared definitions for the parametrised trigger-and-leak Trojan benchmark:
// FSM state encoding, default trigger word and a ceiling-log2 helper.
package trojan_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    DONE    = 2'd3
  } trojan_state_e;

  localparam logic [31:0] TRIG_VAL_DEFAULT = 32'h0044ab93;

  // Never returns 0, so a derived index/counter always has at least one bit.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/trojan_chunk_sel.sv
// Combinational chunk mux: picks chunk 'sel' of the monitored bus, and falls
// back to chunk 0 when sel names a chunk that does not exist.
module trojan_chunk_sel
  import trojan_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int CHUNK_W = 4,
  parameter int SEL_W   = clog2(DATA_W / CHUNK_W)
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SEL_W-1:0]   sel,
  output logic [CHUNK_W-1:0] chunk
);

  localparam int NSEL = DATA_W / CHUNK_W;

  always_comb begin
    chunk = data[CHUNK_W-1:0];
    if (int'(sel) < NSEL) chunk = data[sel*CHUNK_W +: CHUNK_W];
  end

endmodule

// File: rtl/trojan_leak_param.sv
// Trigger-and-leak Trojan: on a trigger word, captures NCHUNK chunks of the bus
// into a key and shifts it out LEAK_W bits per cycle. Define TROJAN_REARM_EN to re-arm after DONE.
module trojan_leak_param
  import trojan_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int TRIG_W  = 32,
  parameter logic [TRIG_W-1:0] TRIG_VAL = TRIG_W'(TRIG_VAL_DEFAULT),
  parameter int CHUNK_W = 4,
  parameter int NCHUNK  = 4,
  parameter int LEAK_W  = 2
) (
  input  logic              clk,
  input  logic              rst_all,
  input  logic [DATA_W-1:0] data,
  output logic [LEAK_W-1:0] leak_bits,
  output logic              leak_valid,
  output logic              busy,
  output logic              done
);

  localparam int KEY_W  = CHUNK_W * NCHUNK;
  localparam int NSEL   = DATA_W / CHUNK_W;
  localparam int SEL_W  = clog2(NSEL);
  localparam int NSHIFT = KEY_W / LEAK_W;
  localparam int IDX_W  = clog2(NCHUNK);
  localparam int CNT_W  = clog2(NSHIFT);

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NCHUNK - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSHIFT - 1);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_CAPTURE = CAPTURE;
  localparam logic [1:0] ST_SHIFT   = SHIFT;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]         state;
  logic [KEY_W-1:0]   key;
  logic [SEL_W-1:0]   sel;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;
  logic [CHUNK_W-1:0] chunk;
  logic               trig_hit;
  logic [SEL_W-1:0]   trig_sel;

  assign trig_hit = (data[TRIG_W-1:0] == TRIG_VAL);
  assign trig_sel = data[TRIG_W +: SEL_W];

  trojan_chunk_sel #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W),
    .SEL_W   (SEL_W)
  ) u_chunk_sel (
    .data  (data),
    .sel   (sel),
    .chunk (chunk)
  );

  // Trigger matches outside IDLE fall through untouched, so sel stays frozen.
  always_ff @(posedge clk) begin
    if (rst_all) begin
      state <= ST_IDLE;
      key   <= '0;
      sel   <= '0;
      idx   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig_hit) begin
            sel   <= trig_sel;
            idx   <= '0;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          key[idx*CHUNK_W +: CHUNK_W] <= chunk;
          idx <= idx + 1'b1;
          if (idx == IDX_LAST) begin
            cnt   <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          key <= key >> LEAK_W;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_DONE;
        end
        ST_DONE: begin
`ifdef TROJAN_REARM_EN
          state <= ST_IDLE;
          key   <= '0;
`else
          state <= ST_DONE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign leak_valid = (state == ST_SHIFT);
  assign leak_bits  = leak_valid ? key[LEAK_W-1:0] : '0;
  assign busy       = (state == ST_CAPTURE) || (state == ST_SHIFT);
  assign done       = (state == ST_DONE);

endmodule

// File: tb/tb_trojan_leak_param.sv
// Self-checking bench for trojan_leak_param; expectations follow TROJAN_REARM_EN when it is defined.
module tb_trojan_leak_param;

  localparam logic [31:0] TRIG_VAL = 32'h0044ab93;
  localparam int RUN_LEN = 20;

  logic        clk = 1'b0;
  logic        rst_all = 1'b1;
  logic [63:0] data = '0;
  logic [1:0]  leak_bits;
  logic        leak_valid;
  logic        busy;
  logic        done;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] cap_words [4];
  logic [1:0]  obs_bits  [1:RUN_LEN];
  logic        obs_valid [1:RUN_LEN];
  logic        obs_busy  [1:RUN_LEN];
  logic        obs_done  [1:RUN_LEN];

  trojan_leak_param dut (
    .clk        (clk),
    .rst_all    (rst_all),
    .data       (data),
    .leak_bits  (leak_bits),
    .leak_valid (leak_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] rand_word();
    logic [63:0] w;
    w = {$urandom, $urandom};
    if (w[31:0] == TRIG_VAL) w[0] = ~w[0];
    return w;
  endfunction

  function automatic logic [63:0] trig_word(input logic [3:0] sel);
    logic [63:0] w;
    w = rand_word();
    w[31:0] = TRIG_VAL;
    w[35:32] = sel;
    return w;
  endfunction

  // Key = chunk 'sel' of each capture word, first capture in the low nibble.
  function automatic logic [15:0] model_key(input logic [63:0] trig);
    int sel;
    logic [63:0] key;
    sel = int'(trig[35:32]);
    key = 0;
    for (int i = 0; i < 4; i++)
      key = key | (((cap_words[i] >> (sel * 4)) & 64'hF) << (4 * i));
    return key[15:0];
  endfunction

  // Cycle k after the trigger edge: 1..4 capture, 5..12 shift, 13 onward done.
  function automatic logic [4:0] exp_vec(input int k, input logic [15:0] key);
    logic e_busy, e_valid, e_done;
    logic [15:0] sh;
    e_busy  = (k >= 1) && (k <= 12);
    e_valid = (k >= 5) && (k <= 12);
`ifdef TROJAN_REARM_EN
    e_done  = (k == 13);
`else
    e_done  = (k >= 13);
`endif
    sh = e_valid ? (key >> (2 * (k - 5))) : 16'h0;
    return {e_busy, e_valid, e_done, sh[1:0]};
  endfunction

  task automatic do_reset();
    rst_all = 1'b1;
    data = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_all = 1'b0;
  endtask

  // Presents trig then the capture words, recording outputs for cycles 1..RUN_LEN.
  task automatic run_seq(input logic [63:0] trig, input bit mid_en, input logic [63:0] mid_word);
    data = trig;
    @(posedge clk);
    #1;
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (k <= 4) data = cap_words[k-1];
      else if (mid_en && k == 7) data = mid_word;
      else data = rand_word();
      obs_bits[k]  = leak_bits;
      obs_valid[k] = leak_valid;
      obs_busy[k]  = busy;
      obs_done[k]  = done;
      @(posedge clk);
      #1;
    end
    data = '0;
  endtask

  task automatic test_reset();
    rst_all = 1'b1;
    data = trig_word(4'd3);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({busy, leak_valid, done, leak_bits} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got %b expected 00000", {busy, leak_valid, done, leak_bits});
    end
    rst_all = 1'b0;
    data = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({busy, leak_valid, done, leak_bits} !== 5'b0) begin
        tests_failed++;
        $display("[TB] FAIL idle_zero cycle %0d: got %b expected 00000", i, {busy, leak_valid, done, leak_bits});
      end
    end
  endtask

  task automatic test_nominal();
    logic [63:0] trig;
    logic [15:0] key;
    logic [1:0] ref_seq [8];
    int n_valid;
    ref_seq = '{2'd2, 2'd2, 2'd3, 2'd2, 2'd0, 2'd3, 2'd1, 2'd3};
    do_reset();
    trig = 64'h0000_0003_0044_ab93;
    for (int i = 0; i < 4; i++) begin
      cap_words[i] = rand_word();
      cap_words[i][15:12] = 4'(4'hA + i);
    end
    key = model_key(trig);
    run_seq(trig, 1'b0, '0);
    n_valid = 0;
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (obs_valid[k]) n_valid++;
      tests_run++;
      if ({obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]} !== exp_vec(k, key)) begin
        tests_failed++;
        $display("[TB] FAIL nominal cycle %0d: got %b expected %b", k,
                 {obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]}, exp_vec(k, key));
      end
    end
    for (int j = 0; j < 8; j++) begin
      tests_run++;
      if (obs_bits[5+j] !== ref_seq[j]) begin
        tests_failed++;
        $display("[TB] FAIL nominal_symbol %0d: got %0d expected %0d", j, obs_bits[5+j], ref_seq[j]);
      end
    end
    tests_run++;
    if (n_valid != 8) begin
      tests_failed++;
      $display("[TB] FAIL nominal_valid_count: got %0d expected 8", n_valid);
    end
  endtask

  task automatic test_random();
    logic [63:0] trig;
    logic [15:0] key;
    for (int it = 0; it < 6; it++) begin
      do_reset();
      trig = trig_word(4'($urandom_range(0, 15)));
      for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
      key = model_key(trig);
      run_seq(trig, 1'b0, '0);
      for (int k = 1; k <= RUN_LEN; k++) begin
        tests_run++;
        if ({obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]} !== exp_vec(k, key)) begin
          tests_failed++;
          $display("[TB] FAIL random it %0d cycle %0d: got %b expected %b", it, k,
                   {obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]}, exp_vec(k, key));
        end
      end
    end
  endtask

  task automatic test_near_miss();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      data = rand_word();
      if (i < 10) data[31:0] = 32'h0044ab92;
      else data[31:0] = TRIG_VAL ^ (32'h1 << $urandom_range(0, 31));
      @(posedge clk);
      #1;
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL near_miss cycle %0d: busy got %b expected 0 (data %h)", i, busy, data);
      end
    end
    data = '0;
  endtask

  task automatic test_mid_shift_trigger();
    logic [63:0] trig;
    logic [15:0] key;
    do_reset();
    trig = trig_word(4'd3);
    for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
    key = model_key(trig);
    run_seq(trig, 1'b1, trig_word(4'd5));
    for (int k = 1; k <= RUN_LEN; k++) begin
      tests_run++;
      if ({obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]} !== exp_vec(k, key)) begin
        tests_failed++;
        $display("[TB] FAIL mid_shift_trigger cycle %0d: got %b expected %b", k,
                 {obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]}, exp_vec(k, key));
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    logic [63:0] trig;
    logic [15:0] key;
    int n_valid;
    do_reset();
    trig = trig_word(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
    data = trig;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 6; k++) begin
      data = (k <= 4) ? cap_words[k-1] : rand_word();
      @(posedge clk);
      #1;
    end
    tests_run++;
    if (leak_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL third_shift_valid: got %b expected 1", leak_valid);
    end
    rst_all = 1'b1;
    data = trig_word(4'd5);
    @(posedge clk);
    #1;
    rst_all = 1'b0;
    data = rand_word();
    tests_run++;
    if ({busy, leak_valid, done, leak_bits} !== 5'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid_shift: got %b expected 00000", {busy, leak_valid, done, leak_bits});
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_beats_trigger: busy got %b expected 0", busy);
    end
    trig = trig_word(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
    key = model_key(trig);
    run_seq(trig, 1'b0, '0);
    n_valid = 0;
    for (int k = 1; k <= RUN_LEN; k++) begin
      if (obs_valid[k]) n_valid++;
      tests_run++;
      if ({obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]} !== exp_vec(k, key)) begin
        tests_failed++;
        $display("[TB] FAIL post_reset_leak cycle %0d: got %b expected %b", k,
                 {obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]}, exp_vec(k, key));
      end
    end
    tests_run++;
    if (n_valid != 8) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_valid_count: got %0d expected 8", n_valid);
    end
  endtask

  task automatic test_second_trigger();
    logic [63:0] trig;
    logic [15:0] key;
    logic [4:0] expv;
    do_reset();
    trig = trig_word(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
    run_seq(trig, 1'b0, '0);
    trig = trig_word(4'($urandom_range(0, 15)));
    for (int i = 0; i < 4; i++) cap_words[i] = rand_word();
    key = model_key(trig);
    run_seq(trig, 1'b0, '0);
    for (int k = 1; k <= RUN_LEN; k++) begin
`ifdef TROJAN_REARM_EN
      expv = exp_vec(k, key);
`else
      expv = 5'b00100;
`endif
      tests_run++;
      if ({obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]} !== expv) begin
        tests_failed++;
        $display("[TB] FAIL second_trigger cycle %0d: got %b expected %b", k,
                 {obs_busy[k], obs_valid[k], obs_done[k], obs_bits[k]}, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_random();
    test_near_miss();
    test_mid_shift_trigger();
    test_reset_mid_shift();
    test_second_trigger();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
